instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 64'h0, giving the PC value loaded on reset.
REQ-002 The module SHALL have one clock and one reset: asynchronous, active-high reset.
REQ-003 Port: CLK  input  1  rising-edge clock.
REQ-004 Port: Reset  input  1  asynchronous active-high reset.
REQ-005 Port: NextPC  input  64  next PC from next-PC logic.
REQ-006 Port: NextPCValid  input  1  NextPC is resolved for the current instruction.
REQ-007 Port: IMemReq  output  1  instruction memory request.
REQ-008 Port: IMemAddr  output  64  instruction memory address.
REQ-009 Port: IMemAck  input  1  memory response valid, with IMemData.
REQ-010 Port: IMemData  input  32  instruction word.
REQ-011 Port: Instruction  output  32  captured instruction to decode.
REQ-012 Port: InstrValid  output  1  Instruction is valid.
REQ-013 Port: InstrReady  input  1  decode accepts Instruction.
REQ-014 Port: CurrentPC  output  64  PC of the instruction in flight, fed to next-PC logic.
REQ-015 Port: Misaligned  output  1  sticky fault: a loaded NextPC had bits [1:0] != 0.
REQ-016 Port: FetchCount  output  32  count of completed decode handshakes.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, ISSUE, WAIT_NEXT and HALT.
REQ-018 IDLE SHALL go to REQ on the first rising edge after Reset deasserts.
REQ-019 In REQ, IMemReq SHALL be 1 and IMemAddr SHALL equal CurrentPC; both SHALL stay stable until IMemAck=1 is sampled.
REQ-020 IMemAck=1 in REQ SHALL capture IMemData into Instruction and move to ISSUE on the same edge; zero-wait ack (ack in the first REQ cycle) SHALL be legal.
REQ-021 IMemAck SHALL be ignored in every state other than REQ.
REQ-022 In ISSUE, InstrValid SHALL be 1 and Instruction SHALL be held until InstrReady=1 is sampled; then the FSM SHALL go to WAIT_NEXT and FetchCount SHALL increment.
REQ-023 FetchCount SHALL wrap from 32'hFFFFFFFF to 0.
REQ-024 In WAIT_NEXT, NextPCValid=1 SHALL load CurrentPC<=NextPC and go to REQ; NextPCValid SHALL be ignored in every other state.
REQ-025 If NextPC[1:0]!=0 when loaded, CurrentPC SHALL still load, Misaligned SHALL set, and the FSM SHALL go to HALT.
REQ-026 HALT SHALL be absorbing until Reset, with IMemReq=0 and InstrValid=0.
REQ-027 CurrentPC SHALL change only on a REQ-024 load or on reset.
REQ-028 Minimum instruction period SHALL be 3 cycles: REQ, then ISSUE, then WAIT_NEXT, assuming zero-wait ack and same-cycle ready/valid.
REQ-029 IMemReq and InstrValid SHALL be decoded from the registered state only, with no combinational path from any input.

Reset
REQ-030 Reset SHALL asynchronously force: state=IDLE, CurrentPC=RESET_PC, Instruction=0, IMemReq=0, InstrValid=0, Misaligned=0, FetchCount=0.
REQ-031 Reset asserted mid-transaction (any state) SHALL abandon it; an IMemAck arriving after reset release while in IDLE SHALL be ignored.

Structure
REQ-032 The FSM state encoding, RESET_PC default and instruction width (32) SHALL live in a shared processor package.
REQ-033 The PC register with load enable SHALL be one sub-module, pc_register; the FSM and counter SHALL stay in instr_fetch_unit.

Verification
REQ-034 Reset release, IMemAck tied 1, InstrReady tied 1, NextPCValid=1 with NextPC=CurrentPC+4: IMemAddr SHALL go 0x0, 0x4, 0x8, one address every 3 cycles, and FetchCount=3 after three instructions.
REQ-035 IMemAck delayed 4 cycles at PC 0x10: IMemReq and IMemAddr=0x10 SHALL be held for 4 cycles; Instruction SHALL equal the IMemData presented on the ack cycle, e.g. 0xF84003E9.
REQ-036 InstrReady low for 5 cycles: InstrValid and Instruction SHALL remain stable for those cycles, and FetchCount SHALL increment only once.
REQ-037 NextPC=0x102 in WAIT_NEXT: Misaligned=1, state=HALT, and no further IMemReq until Reset.
REQ-038 Reset pulsed while in REQ, with IMemAck arriving 1 cycle after release: CurrentPC=RESET_PC, the ack SHALL be ignored, and a new request SHALL issue to RESET_PC.
REQ-039 FetchCount preset near wrap (force 32'hFFFFFFFF), one handshake: FetchCount SHALL read 0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared processor definitions for the fetch stage: state encoding, widths
// and the default reset PC.
package instr_fetch_unit_pkg;

   localparam int PC_W    = 64;
   localparam int INSTR_W = 32;

   localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 64'h0;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_REQ       = 3'd1,
      ST_ISSUE     = 3'd2,
      ST_WAIT_NEXT = 3'd3,
      ST_HALT      = 3'd4
   } fetch_state_t;

   function automatic logic pc_misaligned(input logic [PC_W-1:0] pc);
      return pc[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: next-PC input, instruction memory and decode handshakes.
// Handshakes: a request/valid stays asserted with stable payload until its ack/ready is sampled high on a clock edge.
interface instr_fetch_unit_if;
   import instr_fetch_unit_pkg::*;

   logic [PC_W-1:0]    next_pc;
   logic               next_pc_valid;
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_data;
   logic [INSTR_W-1:0] instruction;
   logic               instr_valid;
   logic               instr_ready;
   logic [PC_W-1:0]    current_pc;

   modport master (
      input  next_pc, next_pc_valid, imem_ack, imem_data, instr_ready,
      output imem_req, imem_addr, instruction, instr_valid, current_pc
   );

   modport slave (
      output next_pc, next_pc_valid, imem_ack, imem_data, instr_ready,
      input  imem_req, imem_addr, instruction, instr_valid, current_pc
   );

endinterface

// File: rtl/instr_fetch_unit_pc_register.sv
// Program counter register with load enable; reset loads RESET_PC.
module pc_register
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [PC_W-1:0] d,
   output logic [PC_W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= RESET_PC;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch FSM: request a word at CurrentPC, hand it to decode,
// then wait for the resolved next PC. Misaligned next PC halts fetching.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic [PC_W-1:0]    NextPC,
   input  logic               NextPCValid,
   output logic               IMemReq,
   output logic [PC_W-1:0]    IMemAddr,
   input  logic               IMemAck,
   input  logic [INSTR_W-1:0] IMemData,
   output logic [INSTR_W-1:0] Instruction,
   output logic               InstrValid,
   input  logic               InstrReady,
   output logic [PC_W-1:0]    CurrentPC,
   output logic               Misaligned,
   output logic [31:0]        FetchCount,
   output fetch_state_t       State
);

   fetch_state_t       state;
   fetch_state_t       state_next;
   logic               pc_load;
   logic               instr_capture;
   logic               count_inc;
   logic [INSTR_W-1:0] instruction_q;
   logic               misaligned_q;
   logic [31:0]        fetch_count;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next    = state;
      pc_load       = 1'b0;
      instr_capture = 1'b0;
      count_inc     = 1'b0;
      unique case (state)
         ST_IDLE: state_next = ST_REQ;
         ST_REQ: begin
            if (IMemAck) begin
               instr_capture = 1'b1;
               state_next    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (InstrReady) begin
               count_inc  = 1'b1;
               state_next = ST_WAIT_NEXT;
            end
         end
         ST_WAIT_NEXT: begin
            if (NextPCValid) begin
               pc_load    = 1'b1;
               state_next = pc_misaligned(NextPC) ? ST_HALT : ST_REQ;
            end
         end
         ST_HALT: state_next = ST_HALT;
         default: state_next = ST_IDLE;
      endcase
   end

   // A misaligned target is still loaded so CurrentPC shows the faulting address.
   pc_register #(.RESET_PC(RESET_PC)) u_pc (
      .clk  (CLK),
      .rst  (Reset),
      .load (pc_load),
      .d    (NextPC),
      .q    (CurrentPC)
   );

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         instruction_q <= '0;
         misaligned_q  <= 1'b0;
         fetch_count   <= '0;
      end else begin
         if (instr_capture) begin
            instruction_q <= IMemData;
         end
         if (pc_load && pc_misaligned(NextPC)) begin
            misaligned_q <= 1'b1;
         end
         if (count_inc) begin
            fetch_count <= fetch_count + 32'd1;
         end
      end
   end

   assign IMemReq     = (state == ST_REQ);
   assign InstrValid  = (state == ST_ISSUE);
   assign IMemAddr    = CurrentPC;
   assign Instruction = instruction_q;
   assign Misaligned  = misaligned_q;
   assign FetchCount  = fetch_count;
   assign State       = state;

endmodule
